// File: rtl/mult_stream_engine_if.sv
// ---------------------------------------------------------------------------
// mult_stream_engine_if
// Bus bundle between an operand producer and mult_stream_engine.
//   write_req        producer -> engine  push request
//   fifo_write_data  producer -> engine  {multiplicand[2W-1:W], multiplier[W-1:0]}
//   left_sig         engine -> producer  free FIFO entries (DEPTH..0)
//   full             engine -> producer  FIFO full
//   overflow         engine -> producer  1-cycle pulse, push was dropped
//   busy             engine -> producer  multiply sequence in progress
//   product          engine -> producer  last result, held until the next one
//   product_valid    engine -> producer  1-cycle strobe, product updated
// Modports: master = producer side, slave = engine side.
// ---------------------------------------------------------------------------
interface mult_stream_engine_if #(
  parameter int W  = 8,
  parameter int AW = 4
);
  logic            write_req;
  logic [2*W-1:0]  fifo_write_data;
  logic [AW:0]     left_sig;
  logic            full;
  logic            overflow;
  logic            busy;
  logic [2*W-1:0]  product;
  logic            product_valid;

  modport master (
    output write_req, fifo_write_data,
    input  left_sig, full, overflow, busy, product, product_valid
  );

  modport slave (
    input  write_req, fifo_write_data,
    output left_sig, full, overflow, busy, product, product_valid
  );
endinterface

// File: rtl/mult_stream_engine.sv
// ---------------------------------------------------------------------------
// mult_stream_engine
// FIFO-fed sequential shift-add multiplier. Operand pairs are pushed into a
// DEPTH-entry FIFO; a control FSM pops one pair at a time, runs a W-cycle
// shift-add multiply and presents the 2W-bit result with a 1-cycle strobe.
// Pop in cycle N gives product_valid in cycle N+W+2; back-to-back throughput
// is one result every W+3 cycles.
// Ports:
//   clk    in  system clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   bus    slave modport of mult_stream_engine_if (push side and result side)
// Configuration macro:
//   SIGNED_MULT_EN  defined   -> operands are two's complement, signed product
//                   undefined -> unsigned only, no sign logic
// ---------------------------------------------------------------------------
module mult_stream_engine #(
  parameter int W     = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mult_stream_engine_if.slave  bus
);

  localparam int PW = 2 * W;
  localparam int CW = $clog2(W);
  localparam logic [AW:0]   DEPTH_L  = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   ONE_L    = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE  = {{(AW - 1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW - 1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CALC = 2'd2,
    ST_DONE = 2'd3
  } state_t;

`ifdef SIGNED_MULT_EN
  localparam logic [PW-1:0] ONE_PW = {{(PW - 1){1'b0}}, 1'b1};

  // Magnitude of a W-bit two's complement value; the most negative value
  // maps to 2^(W-1), which still fits in W unsigned bits.
  function automatic logic [W-1:0] magnitude(input logic [W-1:0] v);
    magnitude = v[W-1] ? (~v + {{(W - 1){1'b0}}, 1'b1}) : v;
  endfunction
`endif

  // FIFO storage and status
  logic [PW-1:0] mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [PW-1:0] rd_data_r;
  logic [AW:0]   left_r;
  logic [AW:0]   left_next_s;
  logic          full_r;
  logic          overflow_r;
  logic          push_s;
  logic          pop_s;
  logic          empty_s;

  // Multiplier datapath and control
  state_t        state_r;
  logic          busy_r;
  logic [W-1:0]  mcand_r;
  logic [W-1:0]  mplier_r;
  logic [PW-1:0] acc_r;
  logic [CW-1:0] cnt_r;
  logic [PW-1:0] partial_s;
  logic [PW-1:0] acc_next_s;
  logic [PW-1:0] result_s;
  logic [PW-1:0] product_r;
  logic          product_valid_r;
`ifdef SIGNED_MULT_EN
  logic          sign_r;
`endif

  // Acceptance uses the registered full flag, so a pop in the same cycle
  // cannot rescue a push that arrives while full.
  assign push_s  = bus.write_req & ~full_r;
  assign empty_s = (left_r == DEPTH_L);
  assign pop_s   = (state_r == ST_IDLE) & ~empty_s;

  // Free-entry count after this cycle's accepted push and pop
  always_comb begin
    left_next_s = left_r;
    case ({push_s, pop_s})
      2'b10:   left_next_s = left_r - ONE_L;
      2'b01:   left_next_s = left_r + ONE_L;
      default: left_next_s = left_r;
    endcase
  end

  // FIFO storage write port (data array needs no reset)
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= bus.fifo_write_data;
    end
  end

  // FIFO pointers, registered read data and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      rd_data_r  <= {PW{1'b0}};
      left_r     <= DEPTH_L;
      full_r     <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r  <= rd_ptr_r + PTR_ONE;
        rd_data_r <= mem_r[rd_ptr_r];
      end
      left_r     <= left_next_s;
      full_r     <= (left_next_s == {(AW + 1){1'b0}});
      overflow_r <= bus.write_req & full_r;
    end
  end

  // One shift-add step: add the multiplicand shifted by the bit position
  // whenever the current multiplier LSB is set.
  assign partial_s  = mplier_r[0] ? ({{W{1'b0}}, mcand_r} << cnt_r) : {PW{1'b0}};
  assign acc_next_s = acc_r + partial_s;

`ifdef SIGNED_MULT_EN
  assign result_s = sign_r ? (~acc_next_s + ONE_PW) : acc_next_s;
`else
  assign result_s = acc_next_s;
`endif

  // Control FSM; product is written on the final CALC step so it and its
  // strobe are both visible during DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r         <= ST_IDLE;
      busy_r          <= 1'b0;
      mcand_r         <= {W{1'b0}};
      mplier_r        <= {W{1'b0}};
      acc_r           <= {PW{1'b0}};
      cnt_r           <= {CW{1'b0}};
      product_r       <= {PW{1'b0}};
      product_valid_r <= 1'b0;
`ifdef SIGNED_MULT_EN
      sign_r          <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          product_valid_r <= 1'b0;
          if (pop_s) begin
            state_r <= ST_LOAD;
            busy_r  <= 1'b1;
          end
        end
        ST_LOAD: begin
`ifdef SIGNED_MULT_EN
          mcand_r  <= magnitude(rd_data_r[PW-1:W]);
          mplier_r <= magnitude(rd_data_r[W-1:0]);
          sign_r   <= rd_data_r[PW-1] ^ rd_data_r[W-1];
`else
          mcand_r  <= rd_data_r[PW-1:W];
          mplier_r <= rd_data_r[W-1:0];
`endif
          acc_r   <= {PW{1'b0}};
          cnt_r   <= {CW{1'b0}};
          state_r <= ST_CALC;
        end
        ST_CALC: begin
          acc_r    <= acc_next_s;
          mplier_r <= {1'b0, mplier_r[W-1:1]};
          cnt_r    <= cnt_r + CNT_ONE;
          // Always exactly W steps, zero operands included
          if (cnt_r == CNT_LAST) begin
            product_r       <= result_s;
            product_valid_r <= 1'b1;
            state_r         <= ST_DONE;
          end
        end
        ST_DONE: begin
          product_valid_r <= 1'b0;
          busy_r          <= 1'b0;
          state_r         <= ST_IDLE;
        end
        default: begin
          product_valid_r <= 1'b0;
          busy_r          <= 1'b0;
          state_r         <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.left_sig      = left_r;
  assign bus.full          = full_r;
  assign bus.overflow      = overflow_r;
  assign bus.busy          = busy_r;
  assign bus.product       = product_r;
  assign bus.product_valid = product_valid_r;

endmodule

// File: tb/tb_mult_stream_engine.sv
// ---------------------------------------------------------------------------
// tb_mult_stream_engine
// Self-checking bench for mult_stream_engine (W=8, DEPTH=16). Expected
// products come from plain integer multiplication of the pushed operands;
// signed interpretation follows SIGNED_MULT_EN as in the design.
// ---------------------------------------------------------------------------
module tb_mult_stream_engine;

  localparam int W     = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int LAT   = W + 2;   // pop cycle to strobe cycle
  localparam int THR   = W + 3;   // strobe spacing when back-to-back

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   cyc;

  logic [15:0] got_q[$];
  int          got_cyc_q[$];

  mult_stream_engine_if #(.W(W), .AW(AW)) bus ();

  mult_stream_engine #(.W(W), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter
  always @(posedge clk) cyc <= cyc + 1;

  // Result monitor: record every strobe with its cycle stamp
  always @(negedge clk) begin
    if (rst_n && bus.product_valid === 1'b1) begin
      got_q.push_back(bus.product);
      got_cyc_q.push_back(cyc);
    end
  end

  // Reference product from plain arithmetic on the operand pair
  function automatic logic [15:0] ref_mult(input logic [15:0] pair);
    int a;
    int b;
`ifdef SIGNED_MULT_EN
    a = int'($signed(pair[15:8]));
    b = int'($signed(pair[7:0]));
`else
    a = int'(pair[15:8]);
    b = int'(pair[7:0]);
`endif
    return 16'(a * b);
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_results();
    got_q.delete();
    got_cyc_q.delete();
  endtask

  task automatic wait_results(input int n, input int budget);
    int k;
    k = 0;
    while (got_q.size() < n && k < budget) begin
      step();
      k++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.write_req = 1'b0;
    bus.fifo_write_data = 16'h0000;
    step();
    step();
    checks++;
    if (bus.left_sig !== 5'd16 || bus.full !== 1'b0 || bus.overflow !== 1'b0 ||
        bus.busy !== 1'b0 || bus.product !== 16'h0000 || bus.product_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: left=%0d full=%b ovf=%b busy=%b prod=%h pv=%b, required 16 0 0 0 0000 0",
               bus.left_sig, bus.full, bus.overflow, bus.busy, bus.product, bus.product_valid);
    end
    rst_n = 1'b1;
    step();
    step();
    checks++;
    if (bus.left_sig !== 5'd16 || bus.busy !== 1'b0 || bus.product_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: left=%0d busy=%b pv=%b, required 16 0 0",
               bus.left_sig, bus.busy, bus.product_valid);
    end
  endtask

  task automatic test_single();
    int pop_cyc;
    clear_results();
    bus.write_req = 1'b1;
    bus.fifo_write_data = 16'h0C0A;
    step();
    bus.write_req = 1'b0;
    pop_cyc = cyc;   // entry visible now, so the pop is this cycle
    checks++;
    if (bus.left_sig !== 5'd15) begin
      errors++;
      $display("FAIL single_left_after_push: got %0d, required 15", bus.left_sig);
    end
    step();
    checks++;
    if (bus.left_sig !== 5'd16 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL single_after_pop: left=%0d busy=%b, required 16 1", bus.left_sig, bus.busy);
    end
    wait_results(1, 30);
    checks++;
    if (got_q.size() !== 1) begin
      errors++;
      $display("FAIL single_count: got %0d results, required 1", got_q.size());
    end else begin
      checks++;
      if (got_q[0] !== 16'h0078) begin
        errors++;
        $display("FAIL single_product: got %h, required 0078", got_q[0]);
      end
      checks++;
      if (got_cyc_q[0] - pop_cyc !== LAT) begin
        errors++;
        $display("FAIL single_latency: got %0d, required %0d", got_cyc_q[0] - pop_cyc, LAT);
      end
    end
    step();
    step();
    step();
    checks++;
    if (got_q.size() !== 1 || bus.product_valid !== 1'b0 || bus.product !== 16'h0078 ||
        bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL single_hold: results=%0d pv=%b prod=%h busy=%b, required 1 0 0078 0",
               got_q.size(), bus.product_valid, bus.product, bus.busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp0;
    logic [15:0] exp1;
`ifdef SIGNED_MULT_EN
    exp0 = 16'h0001;
    exp1 = 16'hC080;
`else
    exp0 = 16'hFE01;
    exp1 = 16'h3F80;
`endif
    clear_results();
    bus.write_req = 1'b1;
    bus.fifo_write_data = 16'hFFFF;
    step();
    bus.fifo_write_data = 16'h807F;
    step();
    bus.write_req = 1'b0;
    wait_results(2, 40);
    checks++;
    if (got_q.size() !== 2) begin
      errors++;
      $display("FAIL b2b_count: got %0d results, required 2", got_q.size());
    end else begin
      checks++;
      if (got_q[0] !== exp0 || got_q[0] !== ref_mult(16'hFFFF)) begin
        errors++;
        $display("FAIL b2b_first: got %h, required %h", got_q[0], exp0);
      end
      checks++;
      if (got_q[1] !== exp1 || got_q[1] !== ref_mult(16'h807F)) begin
        errors++;
        $display("FAIL b2b_second: got %h, required %h", got_q[1], exp1);
      end
      checks++;
      if (got_cyc_q[1] - got_cyc_q[0] !== THR) begin
        errors++;
        $display("FAIL b2b_spacing: got %0d, required %0d", got_cyc_q[1] - got_cyc_q[0], THR);
      end
    end
    step();
    step();
    step();
  endtask

  // Pushes on 19 consecutive cycles from idle. Pops land one cycle after
  // the first push and then every W+3 cycles, so after push 17 the FIFO
  // holds 16 entries and push 18 is dropped.
  logic [15:0] fill_vals[19];

  task automatic test_fill_overflow();
    clear_results();
    for (int i = 0; i < 19; i++) begin
      fill_vals[i] = 16'($urandom);
      bus.write_req = 1'b1;
      bus.fifo_write_data = fill_vals[i];
      step();
      if (i == 16) begin
        checks++;
        if (bus.left_sig !== 5'd1 || bus.full !== 1'b0) begin
          errors++;
          $display("FAIL fill_almost: left=%0d full=%b, required 1 0", bus.left_sig, bus.full);
        end
      end
      if (i == 17) begin
        checks++;
        if (bus.left_sig !== 5'd0 || bus.full !== 1'b1 || bus.overflow !== 1'b0) begin
          errors++;
          $display("FAIL fill_full: left=%0d full=%b ovf=%b, required 0 1 0",
                   bus.left_sig, bus.full, bus.overflow);
        end
      end
      if (i == 18) begin
        checks++;
        if (bus.overflow !== 1'b1 || bus.left_sig !== 5'd0) begin
          errors++;
          $display("FAIL fill_overflow: ovf=%b left=%0d, required 1 0", bus.overflow, bus.left_sig);
        end
      end
    end
    bus.write_req = 1'b0;
    step();
    checks++;
    if (bus.overflow !== 1'b0 || bus.full !== 1'b1) begin
      errors++;
      $display("FAIL fill_overflow_pulse: ovf=%b full=%b, required 0 1", bus.overflow, bus.full);
    end
    step();
    step();
    step();
  endtask

  // Next pop is due on this cycle while the FIFO is still full.
  task automatic test_push_at_full_pop();
    bus.write_req = 1'b1;
    bus.fifo_write_data = 16'hA5A5;
    step();
    bus.write_req = 1'b0;
    checks++;
    if (bus.overflow !== 1'b1 || bus.left_sig !== 5'd1 || bus.full !== 1'b0) begin
      errors++;
      $display("FAIL full_pop_push: ovf=%b left=%0d full=%b, required 1 1 0",
               bus.overflow, bus.left_sig, bus.full);
    end
    step();
    checks++;
    if (bus.overflow !== 1'b0 || bus.left_sig !== 5'd1) begin
      errors++;
      $display("FAIL full_pop_after: ovf=%b left=%0d, required 0 1", bus.overflow, bus.left_sig);
    end
  endtask

  task automatic test_drain_order();
    wait_results(18, 18 * THR + 40);
    checks++;
    if (got_q.size() !== 18) begin
      errors++;
      $display("FAIL drain_count: got %0d results, required 18", got_q.size());
    end else begin
      for (int i = 0; i < 18; i++) begin
        checks++;
        if (got_q[i] !== ref_mult(fill_vals[i])) begin
          errors++;
          $display("FAIL drain_product[%0d]: got %h, required %h", i, got_q[i], ref_mult(fill_vals[i]));
        end
      end
    end
    step();
    step();
    checks++;
    if (bus.left_sig !== 5'd16 || bus.busy !== 1'b0 || got_q.size() !== 18) begin
      errors++;
      $display("FAIL drain_idle: left=%0d busy=%b results=%0d, required 16 0 18",
               bus.left_sig, bus.busy, got_q.size());
    end
  endtask

  task automatic test_random();
    logic [15:0] exp_q[$];
    int n;
    int gap;
    for (int r = 0; r < 4; r++) begin
      clear_results();
      exp_q.delete();
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) begin
        bus.write_req = 1'b1;
        bus.fifo_write_data = 16'($urandom);
        if (i == 0 && r == 0) bus.fifo_write_data = 16'h0000;
        exp_q.push_back(bus.fifo_write_data);
        step();
        bus.write_req = 1'b0;
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) step();
      end
      wait_results(n, n * THR + 40);
      checks++;
      if (got_q.size() !== n) begin
        errors++;
        $display("FAIL rand_count[%0d]: got %0d results, required %0d", r, got_q.size(), n);
      end else begin
        for (int i = 0; i < n; i++) begin
          checks++;
          if (got_q[i] !== ref_mult(exp_q[i])) begin
            errors++;
            $display("FAIL rand_product[%0d.%0d]: operands %h got %h, required %h",
                     r, i, exp_q[i], got_q[i], ref_mult(exp_q[i]));
          end
          if (i > 0) begin
            checks++;
            if (got_cyc_q[i] - got_cyc_q[i-1] < THR) begin
              errors++;
              $display("FAIL rand_spacing[%0d.%0d]: got %0d, required at least %0d",
                       r, i, got_cyc_q[i] - got_cyc_q[i-1], THR);
            end
          end
        end
      end
      step();
      step();
    end
  endtask

  task automatic test_reset_mid_calc();
    clear_results();
    bus.write_req = 1'b1;
    bus.fifo_write_data = 16'h1234;
    step();
    bus.fifo_write_data = 16'h5678;
    step();
    bus.write_req = 1'b0;
    for (int i = 0; i < 4; i++) step();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.left_sig !== 5'd16 || bus.full !== 1'b0 || bus.overflow !== 1'b0 ||
        bus.busy !== 1'b0 || bus.product !== 16'h0000 || bus.product_valid !== 1'b0) begin
      errors++;
      $display("FAIL midcalc_reset: left=%0d full=%b ovf=%b busy=%b prod=%h pv=%b, required 16 0 0 0 0000 0",
               bus.left_sig, bus.full, bus.overflow, bus.busy, bus.product, bus.product_valid);
    end
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) step();
    checks++;
    if (got_q.size() !== 0 || bus.left_sig !== 5'd16 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL midcalc_after: results=%0d left=%0d busy=%b, required 0 16 0",
               got_q.size(), bus.left_sig, bus.busy);
    end
    bus.write_req = 1'b1;
    bus.fifo_write_data = 16'h0305;
    step();
    bus.write_req = 1'b0;
    wait_results(1, 30);
    checks++;
    if (got_q.size() !== 1 || bus.product !== ref_mult(16'h0305)) begin
      errors++;
      $display("FAIL midcalc_recover: results=%0d prod=%h, required 1 %h",
               got_q.size(), bus.product, ref_mult(16'h0305));
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_fill_overflow();
    test_push_at_full_pop();
    test_drain_order();
    test_random();
    test_reset_mid_calc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
